// File: rtl/clk_sw_pkg.sv
// Shared types and defaults for the clock-switch controller.
package clk_sw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SWITCH,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int HB_TIMEOUT_DEF    = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hb_edge_sync.sv
// Heartbeat 2-FF synchronizer with registered either-edge pulse.
// Input toggle to hb_edge pulse: 3 clk cycles; no backpressure.
module hb_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic hb,
  output logic hb_edge
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      sync_d  <= 1'b0;
      hb_edge <= 1'b0;
    end else begin
      meta    <= hb;
      sync    <= meta;
      sync_d  <= sync;
      hb_edge <= sync ^ sync_d;
    end
  end

endmodule

// File: rtl/clk_sw_ctrl.sv
// Clock-switch request FSM driving a glitch-free mux select after a target heartbeat check.
// Request accepted only in IDLE (req_ready); done/err are one-cycle completion pulses.
module clk_sw_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int HB_TIMEOUT    = HB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic hb0,
  input  logic hb1,
  output logic sel,
  output logic cur_sel,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W = $clog2(max2(SETTLE_CYCLES, HB_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] TO_LIM     = CNT_W'(HB_TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             tgt;
  logic             tgt_nxt;
  logic             sel_nxt;
  logic             cur_nxt;
  logic             hb0_edge;
  logic             hb1_edge;
  logic             tgt_edge;

  hb_edge_sync u_hb0_sync (
    .clk     (clk),
    .rst     (rst),
    .hb      (hb0),
    .hb_edge (hb0_edge)
  );

  hb_edge_sync u_hb1_sync (
    .clk     (clk),
    .rst     (rst),
    .hb      (hb1),
    .hb_edge (hb1_edge)
  );

  // Only the heartbeat of the clock being switched to matters.
  assign tgt_edge = tgt ? hb1_edge : hb0_edge;
  assign cnt_inc  = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tgt     <= 1'b0;
      sel     <= 1'b0;
      cur_sel <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tgt     <= tgt_nxt;
      sel     <= sel_nxt;
      cur_sel <= cur_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    sel_nxt   = sel;
    cur_nxt   = cur_sel;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          tgt_nxt   = req_sel;
          cnt_nxt   = '0;
          state_nxt = (req_sel == cur_sel) ? ST_DONE : ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A live edge on the final timeout cycle still wins over ERR.
        if (tgt_edge) begin
          state_nxt = ST_SWITCH;
          sel_nxt   = tgt;
          cnt_nxt   = '0;
        end else if (cnt_inc == TO_LIM) begin
          state_nxt = ST_ERR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_SWITCH: begin
        if (cnt_inc == SETTLE_LIM) begin
          state_nxt = ST_DONE;
          cur_nxt   = tgt;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_clk_sw_ctrl.sv
// Scoreboard bench for clk_sw_ctrl: predicted done/err events queued at accept, matched on output.
module tb_clk_sw_ctrl;

  localparam int SETTLE = 8;
  localparam int HB_TO  = 64;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel   = 1'b0;
  logic hb0       = 1'b0;
  logic hb1       = 1'b0;
  logic req_ready;
  logic sel;
  logic cur_sel;
  logic busy;
  logic done;
  logic err;

  clk_sw_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .HB_TIMEOUT    (HB_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .hb0       (hb0),
    .hb1       (hb1),
    .sel       (sel),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    bit is_err;
  } evt_t;
  evt_t sb[$];

  // Heartbeat schedule: periodic toggles plus an optional one-shot toggle cycle.
  int hb0_per = 0, hb0_st = 0, hb0_shot = -1;
  int hb1_per = 0, hb1_st = 0, hb1_shot = -1;

  bit m_sel = 0, m_cur = 0;
  int sel_at = -1, cur_at = -1, idle_at = 0;
  bit sel_val = 0, cur_val = 0;
  bit armed = 0, reset_hit = 0, accepted = 0;

  function automatic bit hb_tog(input bit t, input int c);
    int per, st, shot;
    per  = t ? hb1_per  : hb0_per;
    st   = t ? hb1_st   : hb0_st;
    shot = t ? hb1_shot : hb0_shot;
    return (per != 0 && c >= st && (c % per) == 0) || (c == shot);
  endfunction

  task automatic push_evt(input int c, input bit is_err);
    evt_t e;
    e.cyc    = c;
    e.is_err = is_err;
    sb.push_back(e);
  endtask

  // Expected outcome of a request accepted in cycle t0; detection lags a toggle by 3 cycles.
  task automatic predict(input int t0, input bit t);
    int d;
    d = -1;
    if (t == m_cur) begin
      push_evt(t0 + 1, 1'b0);
      idle_at = t0 + 2;
    end else begin
      for (int k = t0 + 1; k <= t0 + HB_TO; k++)
        if (d < 0 && hb_tog(t, k - 3)) d = k;
      if (d >= 0) begin
        sel_at  = d + 1;
        sel_val = t;
        cur_at  = d + 1 + SETTLE;
        cur_val = t;
        push_evt(cur_at, 1'b0);
        idle_at = cur_at + 1;
      end else begin
        push_evt(t0 + 1 + HB_TO, 1'b1);
        idle_at = t0 + 2 + HB_TO;
      end
    end
  endtask

  task automatic observe();
    evt_t e;
    if (reset_hit) begin
      reset_hit = 0;
      armed     = 1;
      m_sel     = 0;
      m_cur     = 0;
      sel_at    = -1;
      cur_at    = -1;
      idle_at   = cyc;
      sb.delete();
    end
    if (!armed) return;
    if (cyc == sel_at) m_sel = sel_val;
    if (cyc == cur_at) m_cur = cur_val;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("evt_missing", cyc, e.cyc);
    end
    if (done || err) begin
      if (sb.size() == 0) begin
        chk("evt_unexpected", int'({done, err}), 0);
      end else begin
        e = sb.pop_front();
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_err", err, e.is_err);
        chk("evt_done", done, !e.is_err);
      end
    end
    chk("sel", sel, m_sel);
    chk("cur_sel", cur_sel, m_cur);
    chk("req_ready", req_ready, !rst && cyc >= idle_at);
    chk("busy", busy, cyc < idle_at);
    chk("done_err_excl", done & err, 0);
  endtask

  task automatic tick();
    accepted = 0;
    if (rst) reset_hit = 1;
    else if (armed && req_valid && cyc >= idle_at) begin
      accepted = 1;
      predict(cyc, req_sel);
    end
    if (hb_tog(1'b0, cyc)) hb0 = ~hb0;
    if (hb_tog(1'b1, cyc)) hb1 = ~hb1;
    @(negedge clk);
    observe();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(!rst && cyc >= idle_at) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(n < 300), 1);
  endtask

  task automatic request(input bit s);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_sel   = s;
    accepted  = 0;
    while (!accepted && n < 300) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    chk("accept_timeout", accepted, 1);
  endtask

  task automatic set_per(input bit t, input int p);
    if (t) begin
      hb1_per = p;
      hb1_st  = cyc;
    end else begin
      hb0_per = p;
      hb0_st  = cyc;
    end
  endtask

  initial begin
    int n, acc;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_sel   = 1'($urandom_range(0, 1));
      hb0       = 1'($urandom_range(0, 1));
      hb1       = 1'($urandom_range(0, 1));
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b0;
    idle(6);

    // Same-sel request from reset state
    request(1'b0);
    wait_idle();
    idle(3);

    // Dead clk1 heartbeat: timeout
    request(1'b1);
    wait_idle();

    // Edge detected on the last timeout cycle: switch wins
    hb1_shot = cyc + 61;
    request(1'b1);
    wait_idle();
    hb1_shot = -1;

    // Edge one cycle too late: timeout, sel stays on clk1
    hb0_shot = cyc + 62;
    request(1'b0);
    wait_idle();
    hb0_shot = -1;
    idle(4);

    // Same-sel on clk1
    request(1'b1);
    wait_idle();

    // Normal switch back to clk0
    set_per(1'b0, 10);
    idle(12);
    request(1'b0);
    wait_idle();

    // Back-to-back requests with req_valid held high
    set_per(1'b1, 10);
    set_per(1'b0, 7);
    idle(5);
    req_valid = 1'b1;
    req_sel   = 1'b1;
    n = 0;
    acc = 0;
    while (acc < 4 && n < 2000) begin
      tick();
      n++;
      if (accepted) begin
        acc++;
        req_sel = ~req_sel;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 4);
    wait_idle();
    idle(3);

    // Reset during SWITCH after sel has moved
    request(1'b1);
    n = 0;
    while (!m_sel && n < 200) begin
      tick();
      n++;
    end
    chk("switch_reached", int'(m_sel), 1);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(12);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
